// File: rtl/rv32i_timer_if.sv
// ---------------------------------------------------------------------------
// rv32i_timer_if
// Request/acknowledge bus between an initiator (master) and the timer (slave).
//   read_i            : read request, held by the master until ack_o
//   write_i           : write request, held by the master until ack_o
//   addr_i            : byte address of the access
//   data_i            : write data
//   data_o            : read data, meaningful only while ack_o=1
//   ack_o             : one-cycle completion strobe
//   illegal_access_o  : error flag, meaningful only while ack_o=1
// Signal names are taken from the slave's point of view.
// ---------------------------------------------------------------------------
interface rv32i_timer_if #(
    parameter int unsigned XLEN = 32
);
    logic            read_i;
    logic            write_i;
    logic [XLEN-1:0] addr_i;
    logic [XLEN-1:0] data_i;
    logic [XLEN-1:0] data_o;
    logic            ack_o;
    logic            illegal_access_o;

    modport master (
        output read_i,
        output write_i,
        output addr_i,
        output data_i,
        input  data_o,
        input  ack_o,
        input  illegal_access_o
    );

    modport slave (
        input  read_i,
        input  write_i,
        input  addr_i,
        input  data_i,
        output data_o,
        output ack_o,
        output illegal_access_o
    );
endinterface

// File: rtl/rv32i_timer.sv
// ---------------------------------------------------------------------------
// rv32i_timer
// RISC-V style machine timer: 64-bit mtime advanced by a programmable
// prescaler, 64-bit mtimecmp, level interrupt when mtime >= mtimecmp.
// Ports:
//   clk_i    : clock, all state changes on the rising edge
//   rst_n_i  : synchronous active-low reset
//   bus      : rv32i_timer_if slave port (read/write request, ack, data)
//   irq_o    : registered timer interrupt, level
// Register map (byte offset from BASE_ADDR):
//   0x00 MTIME_LO  0x04 MTIME_HI  0x08 MTIMECMP_LO  0x0C MTIMECMP_HI
//   0x10 PRESCALE  0x14 CTRL (bit0 EN, bit1 IRQ_EN)
// Each request is answered by one ack cycle, so requests held continuously
// complete at most every second cycle.
// ---------------------------------------------------------------------------
module rv32i_timer #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned     WINDOW    = 32
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    rv32i_timer_if.slave  bus,
    output logic          irq_o
);

    localparam logic [XLEN-1:0] WINDOW_END = XLEN'(WINDOW);
    // Offsets 0x18 and above hold no register even when the window is larger.
    localparam logic [XLEN-1:0] REG_END    = XLEN'(32'h0000_0018);

    localparam logic [2:0] IDX_MTIME_LO = 3'd0;
    localparam logic [2:0] IDX_MTIME_HI = 3'd1;
    localparam logic [2:0] IDX_CMP_LO   = 3'd2;
    localparam logic [2:0] IDX_CMP_HI   = 3'd3;
    localparam logic [2:0] IDX_PRESCALE = 3'd4;
    localparam logic [2:0] IDX_CTRL     = 3'd5;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t          state_r;
    logic            ack_r;
    logic            illegal_r;
    logic [XLEN-1:0] data_r;
    logic            irq_r;
    logic [63:0]     mtime_r;
    logic [31:0]     shadow_r;
    logic [63:0]     mtimecmp_r;
    logic [31:0]     prescale_r;
    logic            ctrl_en_r;
    logic            ctrl_irq_en_r;
    logic [31:0]     pcnt_r;

    logic [XLEN-1:0] offset_s;
    logic [2:0]      reg_idx_s;
    logic            req_s;
    logic            legal_s;
    logic            rd_s;
    logic            wr_s;
    logic [31:0]     wdata_s;
    logic            wr_mtime_lo_s;
    logic            wr_mtime_hi_s;
    logic            wr_cmp_lo_s;
    logic            wr_cmp_hi_s;
    logic            wr_prescale_s;
    logic            wr_ctrl_s;
    logic            tick_s;
    logic [31:0]     pcnt_next_s;
    logic [63:0]     mtime_next_s;
    logic [63:0]     mtimecmp_next_s;
    logic [31:0]     shadow_next_s;
    logic [31:0]     prescale_next_s;
    logic            ctrl_en_next_s;
    logic            ctrl_irq_en_next_s;
    logic            irq_next_s;
    logic [XLEN-1:0] rdata_s;

    // Register read multiplexer; unmapped indices and CTRL spare bits read 0.
    function automatic logic [31:0] read_mux(
        input logic [2:0]  idx,
        input logic [63:0] mtime,
        input logic [31:0] shadow,
        input logic [63:0] cmp,
        input logic [31:0] pre,
        input logic        en,
        input logic        irq_en
    );
        logic [31:0] r;
        r = 32'h0000_0000;
        case (idx)
            IDX_MTIME_LO: r = mtime[31:0];
            IDX_MTIME_HI: r = shadow;
            IDX_CMP_LO:   r = cmp[31:0];
            IDX_CMP_HI:   r = cmp[63:32];
            IDX_PRESCALE: r = pre;
            IDX_CTRL:     r = {30'h0000_0000, irq_en, en};
            default:      r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Address decode, legality check and per-register write strobes.
    always_comb begin
        offset_s  = bus.addr_i - BASE_ADDR;
        reg_idx_s = offset_s[4:2];
        wdata_s   = bus.data_i[31:0];
        req_s     = (state_r == S_IDLE) && (bus.read_i || bus.write_i);
        // The window test is done on the offset so BASE_ADDR+WINDOW can never overflow.
        legal_s   = !(bus.read_i && bus.write_i)
                    && (bus.addr_i[1:0] == 2'b00)
                    && (bus.addr_i >= BASE_ADDR)
                    && (offset_s < WINDOW_END)
                    && (offset_s < REG_END);
        rd_s          = req_s && bus.read_i && legal_s;
        wr_s          = req_s && bus.write_i && legal_s;
        wr_mtime_lo_s = wr_s && (reg_idx_s == IDX_MTIME_LO);
        wr_mtime_hi_s = wr_s && (reg_idx_s == IDX_MTIME_HI);
        wr_cmp_lo_s   = wr_s && (reg_idx_s == IDX_CMP_LO);
        wr_cmp_hi_s   = wr_s && (reg_idx_s == IDX_CMP_HI);
        wr_prescale_s = wr_s && (reg_idx_s == IDX_PRESCALE);
        wr_ctrl_s     = wr_s && (reg_idx_s == IDX_CTRL);
        rdata_s       = XLEN'(read_mux(reg_idx_s, mtime_r, shadow_r, mtimecmp_r,
                                       prescale_r, ctrl_en_r, ctrl_irq_en_r));
    end

    // Next-state values of the timer registers, including write side effects.
    always_comb begin
        tick_s = ctrl_en_r && (pcnt_r == prescale_r);

        // Reprogramming the prescaler or control restarts the tick phase.
        if (wr_prescale_s || wr_ctrl_s) begin
            pcnt_next_s = 32'h0000_0000;
        end else if (tick_s) begin
            pcnt_next_s = 32'h0000_0000;
        end else if (ctrl_en_r) begin
            pcnt_next_s = pcnt_r + 32'd1;
        end else begin
            pcnt_next_s = pcnt_r;
        end

        // A software write to either half wins over a coincident tick.
        if (wr_mtime_lo_s) begin
            mtime_next_s = {mtime_r[63:32], wdata_s};
        end else if (wr_mtime_hi_s) begin
            mtime_next_s = {wdata_s, mtime_r[31:0]};
        end else if (tick_s) begin
            mtime_next_s = mtime_r + 64'd1;
        end else begin
            mtime_next_s = mtime_r;
        end

        mtimecmp_next_s = mtimecmp_r;
        if (wr_cmp_lo_s) begin
            mtimecmp_next_s[31:0] = wdata_s;
        end else if (wr_cmp_hi_s) begin
            mtimecmp_next_s[63:32] = wdata_s;
        end else begin
            mtimecmp_next_s = mtimecmp_r;
        end

        // Reading LO freezes the upper half so a following HI read is coherent.
        if (rd_s && (reg_idx_s == IDX_MTIME_LO)) begin
            shadow_next_s = mtime_r[63:32];
        end else if (wr_mtime_hi_s) begin
            shadow_next_s = wdata_s;
        end else begin
            shadow_next_s = shadow_r;
        end

        prescale_next_s = wr_prescale_s ? wdata_s : prescale_r;

        if (wr_ctrl_s) begin
            ctrl_en_next_s     = wdata_s[0];
            ctrl_irq_en_next_s = wdata_s[1];
        end else begin
            ctrl_en_next_s     = ctrl_en_r;
            ctrl_irq_en_next_s = ctrl_irq_en_r;
        end

        // Compare on the values being loaded this edge so irq_o tracks writes immediately.
        irq_next_s = ctrl_irq_en_next_s && (mtime_next_s >= mtimecmp_next_s);
    end

    // Handshake FSM, registered bus outputs and timer state.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_r       <= S_IDLE;
            ack_r         <= 1'b0;
            illegal_r     <= 1'b0;
            data_r        <= {XLEN{1'b0}};
            irq_r         <= 1'b0;
            mtime_r       <= 64'h0000_0000_0000_0000;
            shadow_r      <= 32'h0000_0000;
            mtimecmp_r    <= 64'hFFFF_FFFF_FFFF_FFFF;
            prescale_r    <= 32'h0000_0000;
            ctrl_en_r     <= 1'b0;
            ctrl_irq_en_r <= 1'b0;
            pcnt_r        <= 32'h0000_0000;
        end else begin
            pcnt_r        <= pcnt_next_s;
            mtime_r       <= mtime_next_s;
            mtimecmp_r    <= mtimecmp_next_s;
            shadow_r      <= shadow_next_s;
            prescale_r    <= prescale_next_s;
            ctrl_en_r     <= ctrl_en_next_s;
            ctrl_irq_en_r <= ctrl_irq_en_next_s;
            irq_r         <= irq_next_s;
            case (state_r)
                S_IDLE: begin
                    if (req_s) begin
                        state_r   <= S_RESP;
                        ack_r     <= 1'b1;
                        illegal_r <= !legal_s;
                        data_r    <= rd_s ? rdata_s : {XLEN{1'b0}};
                    end else begin
                        state_r   <= S_IDLE;
                        ack_r     <= 1'b0;
                        illegal_r <= 1'b0;
                        data_r    <= {XLEN{1'b0}};
                    end
                end
                S_RESP: begin
                    state_r   <= S_IDLE;
                    ack_r     <= 1'b0;
                    illegal_r <= 1'b0;
                    data_r    <= {XLEN{1'b0}};
                end
                default: begin
                    state_r   <= S_IDLE;
                    ack_r     <= 1'b0;
                    illegal_r <= 1'b0;
                    data_r    <= {XLEN{1'b0}};
                end
            endcase
        end
    end

    // Reset asserted during the response cycle withdraws that ack at once.
    assign bus.ack_o            = ack_r & rst_n_i;
    assign bus.illegal_access_o = illegal_r;
    assign bus.data_o           = data_r;
    assign irq_o                = irq_r;

endmodule
